mem_arb: RTL and testbench
==========================

# mem_arb

Single-port memory arbiter and sequencer for the SISC datapath. It shares one unified 32-bit memory between the instruction-fetch path (PC/IR) and the load/store data path. Arbitration between them is round-robin. Each granted access runs through a fixed-latency memory transaction: the block drives the memory port and returns read data with a one-cycle done pulse to the winning requester. It sits between the control unit's fetch/memory-stage signals and the memory array.

## Interface
Parameters:
- AW, 16, address width (matches PC width)
- DW, 32, data/instruction width
- LAT, 2, memory read latency: cycles from the m_en cycle to m_rdata valid; legal range 1..15

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_f  input  1  synchronous, active-high reset
- f_req  input  1  fetch request, level, held until f_done
- f_addr  input  AW  fetch address
- f_rdata  output  DW  fetched instruction word, held until next fetch completion
- f_done  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request, level, held until d_done
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_rdata  output  DW  load data, held until next data-load completion
- d_done  output  1  one-cycle data completion pulse
- m_en  output  1  memory access strobe, high exactly one cycle per transaction
- m_we  output  1  memory write enable, valid only with m_en
- m_addr  output  AW  memory address
- m_wdata  output  DW  memory write data
- m_rdata  input  DW  memory read data, valid LAT cycles after the m_en cycle
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is high at the clock edge, select a winner, latch owner, addr, we and wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - A lone requester wins.
  - If both request, the port other than last_owner wins.
  - last_owner updates at grant.
  - Fetch is always read (m_we=0).
- ISSUE: m_en=1; m_we/m_addr/m_wdata come from latched values. Go to WAIT with cnt=1.
- WAIT:
  - Stays for exactly LAT cycles.
  - On the last WAIT cycle, captures m_rdata into owner's rdata register. Stores do not capture, so rdata is unchanged.
  - Then goes to DONE.
- DONE:
  - Owner's done=1 for this single cycle.
  - Requests are ignored in this cycle.
  - Goes to IDLE.
  - The requester must drop req by the next edge unless it wants a new access.
- Requester inputs changing after grant have no effect on the current transaction.
- Dropping req mid-transaction does not abort: the transaction completes and done still pulses.
- m_addr/m_wdata hold the last latched values between transactions. m_en=0 and m_we=0 outside ISSUE.
- The counter is ceil(log2(LAT+1)) bits minimum; 4 bits is sufficient for the legal range.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - State = IDLE.
  - last_owner = data, so fetch wins the first contention.
  - m_en, m_we, f_done, d_done and busy = 0.
  - m_addr, m_wdata, f_rdata and d_rdata = 0.
  - cnt = 0.
- Reset mid-transaction: back in IDLE the next cycle with no done pulse. The pending memory response is ignored.
- Request high in cycle N with FSM in IDLE:
  - ISSUE (m_en=1) in cycle N+1.
  - WAIT in cycles N+2..N+1+LAT.
  - rdata captured at end of cycle N+1+LAT.
  - done=1 and rdata visible in cycle N+2+LAT.
  - IDLE in cycle N+3+LAT.
- Peak throughput is one transaction per LAT+3 cycles. A back-to-back request is sampled in the IDLE cycle after DONE.
- Both requests arriving in the same cycle resolve by round-robin. The loser is served in the next transaction if it is still requesting.
- busy is high from ISSUE through DONE inclusive.

## Test plan
- Reset, then fetch only with LAT=2 (f_addr=16'h0004 in cycle 0, memory returns 32'h1234_5678):
  - m_en=1 with m_addr=16'h0004 and m_we=0 in cycle 1.
  - f_done=1 and f_rdata=32'h1234_5678 in cycle 4.
  - d_done remains 0.
- Store (d_we=1, d_addr=16'h0010, d_wdata=32'hDEAD_BEEF):
  - m_en=1, m_we=1, m_addr=16'h0010, m_wdata=32'hDEAD_BEEF for exactly one cycle.
  - d_done pulses 4 cycles after the request.
  - d_rdata is unchanged.
- f_req and d_req both high right after reset:
  - Fetch is granted first.
  - Data is granted in the next transaction, so d_done comes 5 cycles after f_done.
  - With both held continuously, grants alternate F, D, F, D.
- Requester changes d_addr to 16'h0020 during WAIT: m_addr stays 16'h0010 and the captured data corresponds to 16'h0010.
- rst_f=1 asserted during WAIT:
  - Next cycle: state IDLE, busy=0, m_en=0, no done pulse, f_rdata/d_rdata=0.
  - A subsequent fetch completes normally in LAT+2 cycles.
- Repeat the fetch scenario with LAT=1 and LAT=5: f_done arrives in cycle 3 and cycle 7 respectively.

Source files
------------

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Round-robin arbiter and fixed-latency sequencer that shares
//               one 32-bit memory port between the instruction-fetch path and
//               the load/store data path.
//
//               Ports
//                 clk, rst_f            clock, synchronous active-high reset
//                 f_req/f_addr          fetch request (level) and address
//                 f_rdata/f_done        fetched word (held), completion pulse
//                 d_req/d_we/d_addr/    data request (level), store select,
//                 d_wdata               address and store data
//                 d_rdata/d_done        load data (held), completion pulse
//                 m_en/m_we/m_addr/     memory strobe, write enable, address,
//                 m_wdata/m_rdata       write data and read data
//                 busy                  high while a transaction is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_rdata,
    output logic          f_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic       c_OWN_FETCH = 1'b0;
    localparam logic       c_OWN_DATA  = 1'b1;

    localparam logic [3:0] c_LAT = 4'(LAT);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_owner;
    logic          r_last_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_f_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_any_req;
    logic          w_grant;
    logic          w_grant_data;
    logic          w_last_wait;
    logic          w_capture;

    assign w_any_req   = f_req | d_req;
    assign w_grant     = (r_state == c_ST_IDLE) & w_any_req;
    // Under contention the port that did not win last time takes the grant.
    assign w_grant_data = d_req & (~f_req | (r_last_owner == c_OWN_FETCH));
    assign w_last_wait = (r_state == c_ST_WAIT) & (r_cnt == c_LAT);
    assign w_capture   = w_last_wait & ~r_we;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any_req)   w_state_next = c_ST_ISSUE;
            c_ST_ISSUE:                  w_state_next = c_ST_WAIT;
            c_ST_WAIT:  if (w_last_wait) w_state_next = c_ST_DONE;
            c_ST_DONE:                   w_state_next = c_ST_IDLE;
            default:                     w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction latches, latency counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_owner      <= c_OWN_FETCH;
            r_last_owner <= c_OWN_DATA;   // fetch wins the first contention
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= 4'd0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_grant_data;
                r_last_owner <= w_grant_data;
                r_we         <= w_grant_data & d_we;
                r_addr       <= w_grant_data ? d_addr : f_addr;
                // A fetch carries no write data, so the port keeps the last
                // store value rather than picking up an unrelated d_wdata.
                if (w_grant_data) begin
                    r_wdata <= d_wdata;
                end
            end

            if (r_state == c_ST_ISSUE) begin
                r_cnt <= 4'd1;
            end else if ((r_state == c_ST_WAIT) && (r_cnt != c_LAT)) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_capture) begin
                if (r_owner == c_OWN_DATA) begin
                    r_d_rdata <= m_rdata;
                end else begin
                    r_f_rdata <= m_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    assign m_en    = (r_state == c_ST_ISSUE);
    assign m_we    = m_en & r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign f_done  = (r_state == c_ST_DONE) & (r_owner == c_OWN_FETCH);
    assign d_done  = (r_state == c_ST_DONE) & (r_owner == c_OWN_DATA);
    assign busy    = (r_state != c_ST_IDLE);
    assign f_rdata = r_f_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb
// Description : Self-checking bench for mem_arb. A transaction-level model
//               (grant cycle + fixed offsets) predicts every output each
//               cycle; directed scenarios add literal expectations. Two extra
//               instances with LAT=1 and LAT=5 check fetch timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

    localparam int c_AW   = 16;
    localparam int c_DW   = 32;
    localparam int c_LAT0 = 2;
    localparam logic [31:0] c_BAD = 32'hBAD0_BAD0;

    logic          clk;
    logic          rst_f;
    logic          f_req, d_req, d_we;
    logic [c_AW-1:0] f_addr, d_addr;
    logic [c_DW-1:0] d_wdata;
    logic [c_DW-1:0] f_rdata, d_rdata, m_wdata, m_rdata;
    logic          f_done, d_done, m_en, m_we, busy;
    logic [c_AW-1:0] m_addr;

    // LAT=1 / LAT=5 lanes (fetch only)
    logic            f_req_1, f_req_5;
    logic [c_DW-1:0] f_rdata_1, d_rdata_1, m_wdata_1, m_rdata_1;
    logic [c_DW-1:0] f_rdata_5, d_rdata_5, m_wdata_5, m_rdata_5;
    logic            f_done_1, d_done_1, m_en_1, m_we_1, busy_1;
    logic            f_done_5, d_done_5, m_en_5, m_we_5, busy_5;
    logic [c_AW-1:0] m_addr_1, m_addr_5;
    logic            lane_d_req = 1'b0;
    logic            lane_d_we  = 1'b0;
    logic [c_AW-1:0] lane_addr  = 16'h0004;
    logic [c_DW-1:0] lane_wdata = 32'h0;

    mem_arb #(.AW(c_AW), .DW(c_DW), .LAT(c_LAT0)) u_dut (
        .clk(clk), .rst_f(rst_f),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    mem_arb #(.AW(c_AW), .DW(c_DW), .LAT(1)) u_lat1 (
        .clk(clk), .rst_f(rst_f),
        .f_req(f_req_1), .f_addr(lane_addr), .f_rdata(f_rdata_1), .f_done(f_done_1),
        .d_req(lane_d_req), .d_we(lane_d_we), .d_addr(lane_addr), .d_wdata(lane_wdata),
        .d_rdata(d_rdata_1), .d_done(d_done_1),
        .m_en(m_en_1), .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1),
        .m_rdata(m_rdata_1), .busy(busy_1)
    );

    mem_arb #(.AW(c_AW), .DW(c_DW), .LAT(5)) u_lat5 (
        .clk(clk), .rst_f(rst_f),
        .f_req(f_req_5), .f_addr(lane_addr), .f_rdata(f_rdata_5), .f_done(f_done_5),
        .d_req(lane_d_req), .d_we(lane_d_we), .d_addr(lane_addr), .d_wdata(lane_wdata),
        .d_rdata(d_rdata_5), .d_done(d_done_5),
        .m_en(m_en_5), .m_we(m_we_5), .m_addr(m_addr_5), .m_wdata(m_wdata_5),
        .m_rdata(m_rdata_5), .busy(busy_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory: 256 words, read data valid only in cycle (m_en cycle + LAT)
    // ------------------------------------------------------------------
    int              cyc = 0;
    logic [31:0]     mem [0:255];
    int              en_c0 = -100, en_c1 = -100, en_c5 = -100;
    logic [c_AW-1:0] en_a0 = '0, en_a1 = '0, en_a5 = '0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h1234_5678;
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (m_en && m_we) begin
            mem[m_addr[7:0]] <= m_wdata;
        end
        if (m_en)   begin en_c0 <= cyc; en_a0 <= m_addr;   end
        if (m_en_1) begin en_c1 <= cyc; en_a1 <= m_addr_1; end
        if (m_en_5) begin en_c5 <= cyc; en_a5 <= m_addr_5; end
    end

    assign m_rdata   = (cyc == en_c0 + c_LAT0) ? mem[en_a0[7:0]] : c_BAD;
    assign m_rdata_1 = (cyc == en_c1 + 1)      ? mem[en_a1[7:0]] : c_BAD;
    assign m_rdata_5 = (cyc == en_c5 + 5)      ? mem[en_a5[7:0]] : c_BAD;

    // ------------------------------------------------------------------
    // Transaction-level model: a grant at the end of cycle t0 gives
    // ISSUE at t0+1, capture at end of t0+1+LAT, done at t0+2+LAT.
    // ------------------------------------------------------------------
    bit              mdl_active = 1'b0;
    int              mdl_t0     = 0;
    bit              mdl_owner  = 1'b0;   // 1 = data
    bit              mdl_last   = 1'b1;
    bit              mdl_we     = 1'b0;
    logic [c_AW-1:0] mdl_addr   = '0;
    logic [c_DW-1:0] mdl_wdata  = '0;
    logic [c_DW-1:0] exp_f      = '0;
    logic [c_DW-1:0] exp_d      = '0;

    function automatic bit pick_data(input bit f, input bit d, input bit last);
        if (f && d) return !last;   // the other port wins a tie
        return d;
    endfunction

    always @(posedge clk) begin
        if (rst_f) begin
            mdl_active <= 1'b0;
            mdl_last   <= 1'b1;
            mdl_addr   <= '0;
            mdl_wdata  <= '0;
            exp_f      <= '0;
            exp_d      <= '0;
        end else if (!mdl_active) begin
            if (f_req || d_req) begin
                mdl_active <= 1'b1;
                mdl_t0     <= cyc;
                mdl_owner  <= pick_data(f_req, d_req, mdl_last);
                mdl_last   <= pick_data(f_req, d_req, mdl_last);
                mdl_we     <= pick_data(f_req, d_req, mdl_last) && d_we;
                mdl_addr   <= pick_data(f_req, d_req, mdl_last) ? d_addr : f_addr;
                if (pick_data(f_req, d_req, mdl_last)) mdl_wdata <= d_wdata;
            end
        end else begin
            if (cyc == mdl_t0 + 1 + c_LAT0 && !mdl_we) begin
                if (mdl_owner) exp_d <= mem[mdl_addr[7:0]];
                else           exp_f <= mem[mdl_addr[7:0]];
            end
            if (cyc == mdl_t0 + 2 + c_LAT0) mdl_active <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_model();
        bit issue, done;
        issue = mdl_active && (cyc == mdl_t0 + 1);
        done  = mdl_active && (cyc == mdl_t0 + 2 + c_LAT0);
        chk("mdl busy",    32'(busy),   32'(mdl_active));
        chk("mdl m_en",    32'(m_en),   32'(issue));
        chk("mdl m_we",    32'(m_we),   32'(issue && mdl_we));
        chk("mdl f_done",  32'(f_done), 32'(done && !mdl_owner));
        chk("mdl d_done",  32'(d_done), 32'(done && mdl_owner));
        chk("mdl m_addr",  32'(m_addr), 32'(mdl_addr));
        chk("mdl f_rdata", f_rdata, exp_f);
        chk("mdl d_rdata", d_rdata, exp_d);
        if (issue && mdl_we) chk("mdl m_wdata", m_wdata, mdl_wdata);
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    int exp_cyc [4] = '{4, 9, 14, 19};
    bit exp_own [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int dn_cyc  [4];
    bit dn_own  [4];
    int n_dn;

    initial begin
        rst_f = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; f_req_1 = 1'b0; f_req_5 = 1'b0;
        step(); step();
        chk("rst busy",    32'(busy), 0);
        chk("rst m_en",    32'(m_en), 0);
        chk("rst m_addr",  32'(m_addr), 0);
        chk("rst f_rdata", f_rdata, 0);
        rst_f = 1'b0;
        step();

        // Fetch from 0x0004 (cycle 0 = request cycle)
        f_req = 1'b1; f_addr = 16'h0004;
        step();
        chk("fetch m_en",   32'(m_en), 1);
        chk("fetch m_addr", 32'(m_addr), 32'h0004);
        chk("fetch m_we",   32'(m_we), 0);
        step(); step(); step();
        chk("fetch f_done",  32'(f_done), 1);
        chk("fetch f_rdata", f_rdata, 32'h1234_5678);
        chk("fetch d_done",  32'(d_done), 0);
        f_req = 1'b0;
        step();

        // Load from 0x0010, address changes to 0x0020 during WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        step();
        step();
        d_addr = 16'h0020;
        step();
        chk("load m_addr held", 32'(m_addr), 32'h0010);
        step();
        chk("load d_done",  32'(d_done), 1);
        chk("load d_rdata", d_rdata, 32'hC0DE_0010);
        d_req = 1'b0;
        step();

        // Store 0xDEADBEEF to 0x0010
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'hDEAD_BEEF;
        step();
        chk("store m_en",    32'(m_en), 1);
        chk("store m_we",    32'(m_we), 1);
        chk("store m_addr",  32'(m_addr), 32'h0010);
        chk("store m_wdata", m_wdata, 32'hDEAD_BEEF);
        step();
        chk("store m_en one cycle", 32'(m_en), 0);
        step(); step();
        chk("store d_done",    32'(d_done), 1);
        chk("store d_rdata kept", d_rdata, 32'hC0DE_0010);
        d_req = 1'b0; d_we = 1'b0;
        step();

        // Load back the stored word
        d_req = 1'b1; d_addr = 16'h0010;
        step(); step(); step(); step();
        chk("reload d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();

        // Contention right after reset, both held: F, D, F, D
        rst_f = 1'b1;
        step();
        rst_f = 1'b0; f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0004; d_addr = 16'h0020;
        n_dn = 0;
        for (int c = 1; c <= 30 && n_dn < 4; c++) begin
            step();
            if (f_done || d_done) begin
                dn_cyc[n_dn] = c;
                dn_own[n_dn] = d_done;
                n_dn++;
                if (n_dn == 4) begin f_req = 1'b0; d_req = 1'b0; end
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("rr done count", 32'(n_dn), 4);
        for (int i = 0; i < n_dn; i++) begin
            chk("rr done cycle", 32'(dn_cyc[i]), 32'(exp_cyc[i]));
            chk("rr owner",      32'(dn_own[i]), 32'(exp_own[i]));
        end
        step();

        // Reset during WAIT
        f_req = 1'b1; f_addr = 16'h0020;
        step(); step();
        rst_f = 1'b1; f_req = 1'b0;
        step();
        chk("rstw busy",    32'(busy), 0);
        chk("rstw m_en",    32'(m_en), 0);
        chk("rstw f_done",  32'(f_done), 0);
        chk("rstw f_rdata", f_rdata, 0);
        chk("rstw d_rdata", d_rdata, 0);
        rst_f = 1'b0;
        step();
        chk("rstw no late done", 32'(f_done), 0);
        step();
        f_req = 1'b1; f_addr = 16'h0004;
        step(); step(); step(); step();
        chk("post-rst f_done",  32'(f_done), 1);
        chk("post-rst f_rdata", f_rdata, 32'h1234_5678);
        f_req = 1'b0;
        step(); step();

        // LAT=1 and LAT=5 fetch timing
        f_req_1 = 1'b1; f_req_5 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("lat1 f_done", 32'(f_done_1), 32'(c == 3));
            chk("lat5 f_done", 32'(f_done_5), 32'(c == 7));
            if (c == 3) begin
                chk("lat1 f_rdata", f_rdata_1, 32'h1234_5678);
                f_req_1 = 1'b0;
            end
            if (c == 7) begin
                chk("lat5 f_rdata", f_rdata_5, 32'h1234_5678);
                f_req_5 = 1'b0;
            end
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
